instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
- Hardwired control sequencer for the simple CPU. It sits directly upstream of the datapath and drives the strobes that benches currently hand-sequence per T-state.
- Performs instruction fetch (T0–T2), then executes three-register ALU instructions (T3–T5) and MUL/DIV (T3–T6).
- Decodes IR fields into one-hot register in/out selects and the ALU operation code.

Parameters:
- OPW, 5, opcode / ALU operation width
- NREG, 16, number of general registers; width of the one-hot selects
- MEM_WAIT_MAX, 15, maximum cycles T1 waits for mem_ready before faulting

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- run  in  1  level; while high, the sequencer fetches and executes continuously
- mem_ready  in  1  memory read-data-valid handshake
- IR  in  32  instruction register contents from the datapath
- PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin, Zlowout, Zhighout, LOin, HIin  out  1 each  datapath strobes
- Rout  out  NREG  one-hot register-to-bus select
- Rin  out  NREG  one-hot register load select
- operation  out  OPW  ALU operation code
- busy  out  1  high in every state except IDLE and HALT
- instr_done  out  1  one-cycle pulse on the final execute state
- fault  out  1  sticky; set on illegal opcode or memory timeout

Behaviour:
- One clock (Clock). Reset is asynchronous and active-high (Reset).
- Reset:
  - state = IDLE; wait counter = 0; fault = 0.
  - All strobes, Rout, Rin and operation = 0.
- Outputs are Moore outputs: a combinational decode of the registered state plus IR fields. No strobe is ever high in IDLE or HALT.
- IR fields: opcode = IR[31:27], Ra = IR[26:23] (destination), Rb = IR[22:19], Rc = IR[18:15].
- Opcode classes:
  - 00000–01100: ALU three-register; operation = opcode.
  - 01111: MUL. 10000: DIV.
  - 11011: HALT.
  - Everything else: illegal.
- State sequence and outputs:
  - IDLE: if run, go to T0; else stay.
  - T0: PCout, MARin, IncPC, Zin. Next state T1.
  - T1: Zlowout, PCin, Read, MDRin.
    - Stays in T1 while mem_ready = 0; counter increments.
    - mem_ready = 1: go to T2; counter cleared.
    - Counter reaches MEM_WAIT_MAX with mem_ready still 0: fault = 1, go to HALT.
  - T2: MDRout, IRin. Next state DEC.
  - DEC: one cycle, no strobes; IR is now valid.
    - HALT opcode: go to HALT.
    - Illegal opcode: fault = 1, go to HALT.
    - Otherwise: go to T3.
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], Zin, operation = opcode.
  - T5:
    - ALU class: Zlowout, Rin[Ra], instr_done. Next state is T0 if run, else IDLE.
    - MUL/DIV: Zlowout, LOin. Next state T6.
  - T6 (MUL/DIV only): Zhighout, HIin, instr_done. Next state is T0 if run, else IDLE.
  - HALT: absorbing; only Reset leaves it.
- operation holds its last value outside T4 (reset value 0). The ALU samples it only while Zin is high.
- Rout and Rin are each zero or exactly one-hot in every state.
- Deassertion of run mid-instruction completes the current instruction, then the sequencer enters IDLE.
- Reset mid-instruction aborts immediately; no partial strobe is held.
- Rb = Rc is legal: the same register is driven in both T3 and T4.
- Ra may equal Rb or Rc; the write occurs only in T5.
- Latency:
  - ALU instruction with zero-wait memory: 7 cycles T0→T5.
  - MUL/DIV: 8 cycles.

Optional Feature:
- Macro: INSTR_SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - After T5/T6, the sequencer enters state STEPWAIT and stays there until it sees step high, even if run is high.
  - step high in STEPWAIT: go to T0 if run, else IDLE.
  - step high outside STEPWAIT is ignored.
- Undefined: no step port and no STEPWAIT state; behaviour exactly as above.

Test Plan:
- Reset asserted mid-T4 → next sample shows IDLE: all strobes 0, Rout = 0, busy = 0, fault = 0.
- run = 1, mem_ready tied 1, IR = 0x5A1B8000 (SHL R4,R3,R7):
  - T3: Rout = 0x0008, Yin = 1.
  - T4: Rout = 0x0080, Zin = 1, operation = 5'b01011.
  - T5: Zlowout = 1, Rin = 0x0010, instr_done = 1.
  - Required: 7 cycles from T0 to T5.
- IR = 0x781B8000 (MUL):
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin, instr_done.
  - Rin = 0 throughout.
- mem_ready held low for 3 cycles in T1 → T1 lasts 4 cycles; Read and MDRin stay high throughout; no fault.
- mem_ready held low for 15 cycles → fault = 1, state HALT, busy = 0; remains HALT while run = 1.
- IR = 0xF8000000 (opcode 11111, illegal) → fault = 1 after DEC, no T3 strobes. IR = 0xD8000000 (HALT) → HALT with fault = 0.

Source files
------------

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Hardwired control sequencer for the simple CPU. It fetches an instruction
//   (T0-T2), decodes it (DEC), and then executes it. Three-register ALU
//   operations use T3-T5. MUL/DIV use T3-T6. It drives the datapath strobes,
//   the one-hot register selects and the ALU operation code.
//
//   Optional feature (macro INSTR_SEQ_SINGLE_STEP_EN):
//     This adds the input 'step' and the state STEPWAIT. After each
//     instruction completes, the sequencer parks in STEPWAIT until 'step' is
//     seen high.
//
// Ports
//   Clock, Reset           : clock (rising edge), async active-high reset
//   run                    : level; fetch/execute continuously while high
//   mem_ready              : memory read-data-valid handshake (checked in T1)
//   IR[31:0]               : instruction register from the datapath
//   PCout..HIin            : single-bit datapath strobes
//   Rout / Rin [NREG]      : one-hot register-to-bus / register-load selects
//   operation [OPW]        : ALU operation code (held outside T4)
//   busy                   : high in every state except IDLE and HALT
//   instr_done             : one-cycle pulse on the final execute state
//   fault                  : sticky; illegal opcode or memory timeout
//   step (optional)        : single-step release
// ---------------------------------------------------------------------------
module instr_sequencer #(
  parameter int OPW          = 5,
  parameter int NREG         = 16,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            run,
  input  logic            mem_ready,
`ifdef INSTR_SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic [31:0]     IR,
  output logic            PCout,
  output logic            MARin,
  output logic            IncPC,
  output logic            Zin,
  output logic            PCin,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            LOin,
  output logic            HIin,
  output logic [NREG-1:0] Rout,
  output logic [NREG-1:0] Rin,
  output logic [OPW-1:0]  operation,
  output logic            busy,
  output logic            instr_done,
  output logic            fault
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_DEC, S_T3, S_T4, S_T5, S_T6, S_HALT
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    , S_STEPWAIT
`endif
  } state_t;

  state_t         state;
  logic [CW-1:0]  wait_cnt;
  logic [OPW-1:0] op_hold;

  // IR field decode
  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_md, is_halt;
  logic       unused_ir;

  assign opc       = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  assign is_alu  = (opc <= 5'd12);
  assign is_md   = (opc == 5'd15) || (opc == 5'd16);
  assign is_halt = (opc == 5'd27);

  // One-hot register select. An index beyond NREG selects nothing, so the
  // output is always zero or one-hot.
  function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++)
      v[i] = (int'(idx) == i);
    return v;
  endfunction

  // Return point after the last execute state
  function automatic state_t after_exec(input logic r);
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    after_exec = S_STEPWAIT;
    if (r) after_exec = S_STEPWAIT;
`else
    after_exec = r ? S_T0 : S_IDLE;
`endif
  endfunction

  // -------------------------------------------------------------------------
  // State register, memory-wait counter, sticky fault, held ALU operation
  // -------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      fault    <= 1'b0;
      op_hold  <= '0;
    end else begin
      case (state)
        S_IDLE: if (run) state <= S_T0;
        S_T0: begin
          wait_cnt <= '0;
          state    <= S_T1;
        end
        S_T1: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            state    <= S_T2;
          end else if (wait_cnt == CW'(MEM_WAIT_MAX - 1)) begin
            // This wait cycle would bring the count to MEM_WAIT_MAX.
            wait_cnt <= '0;
            fault    <= 1'b1;
            state    <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_T2:  state <= S_DEC;
        S_DEC: begin
          if (is_halt) begin
            state <= S_HALT;
          end else if (is_alu || is_md) begin
            state <= S_T3;
          end else begin
            fault <= 1'b1;
            state <= S_HALT;
          end
        end
        S_T3: state <= S_T4;
        S_T4: begin
          op_hold <= OPW'(opc);
          state   <= S_T5;
        end
        S_T5: state <= is_md ? S_T6 : after_exec(run);
        S_T6: state <= after_exec(run);
`ifdef INSTR_SEQ_SINGLE_STEP_EN
        S_STEPWAIT: if (step) state <= run ? S_T0 : S_IDLE;
`endif
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Moore output decode: registered state plus IR fields
  // -------------------------------------------------------------------------
  always_comb begin
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    Zin        = 1'b0;
    PCin       = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    LOin       = 1'b0;
    HIin       = 1'b0;
    Rout       = '0;
    Rin        = '0;
    instr_done = 1'b0;
    operation  = op_hold;
    case (state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        Rout = onehot(rb);
        Yin  = 1'b1;
      end
      S_T4: begin
        Rout      = onehot(rc);
        Zin       = 1'b1;
        operation = OPW'(opc);
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_md) begin
          LOin = 1'b1;
        end else begin
          Rin        = onehot(ra);
          instr_done = 1'b1;
        end
      end
      S_T6: begin
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE) && (state != S_HALT);

endmodule
